// File: rtl/body_rate_controller.sv
// ============================================================================
// Module   : body_rate_controller
// Purpose  : P rate loop, quad-X mixer and motor limiter; integral term via RATE_INTEGRAL_EN
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module body_rate_controller #(
   parameter int RATE_BIT_WIDTH  = 16,
   parameter int RATE_KP         = 4,
   parameter int RATE_KP_SHIFT   = 2,
   parameter int RATE_TERM_LIMIT = 'h0400,
   parameter int MOTOR_MAX       = 'h0FA0
) (
   input  logic                      us_clk,
   input  logic                      reset,
   input  logic                      start_signal,
   input  logic [RATE_BIT_WIDTH-1:0] throttle_rate_target,
   input  logic [RATE_BIT_WIDTH-1:0] yaw_rate_target,
   input  logic [RATE_BIT_WIDTH-1:0] pitch_rate_target,
   input  logic [RATE_BIT_WIDTH-1:0] roll_rate_target,
   input  logic [RATE_BIT_WIDTH-1:0] yaw_rate_actual,
   input  logic [RATE_BIT_WIDTH-1:0] pitch_rate_actual,
   input  logic [RATE_BIT_WIDTH-1:0] roll_rate_actual,
   output logic [RATE_BIT_WIDTH-1:0] motor_fl,
   output logic [RATE_BIT_WIDTH-1:0] motor_fr,
   output logic [RATE_BIT_WIDTH-1:0] motor_rr,
   output logic [RATE_BIT_WIDTH-1:0] motor_rl,
   output logic                      motor_saturated,
   output logic                      active_signal,
   output logic                      complete_signal
);

   localparam int W    = RATE_BIT_WIDTH;
   localparam int MW   = RATE_BIT_WIDTH + 3;
   localparam int AX_Y = 0;
   localparam int AX_P = 1;
   localparam int AX_R = 2;
   localparam int M_FL = 0;
   localparam int M_FR = 1;
   localparam int M_RR = 2;
   localparam int M_RL = 3;

   localparam logic signed [W-1:0]  E_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0]  E_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [63:0]   T_HI  = 64'(RATE_TERM_LIMIT);
   localparam logic signed [63:0]   T_LO  = -T_HI;
   localparam logic signed [MW-1:0] M_MAX = MW'(MOTOR_MAX);

   typedef enum logic [2:0] {
      ST_WAITING  = 3'd0,
      ST_ERROR    = 3'd1,
      ST_SCALE    = 3'd2,
      ST_MIX      = 3'd3,
      ST_LIMIT    = 3'd4,
      ST_COMPLETE = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic        [W-1:0]  thr_q, thr_d;
   logic signed [W-1:0]  tgt_q[3], tgt_d[3];
   logic signed [W-1:0]  act_q[3], act_d[3];
   logic signed [W-1:0]  err_q[3], err_d[3];
   logic signed [W-1:0]  term_q[3], term_d[3];
   logic signed [MW-1:0] sum_q[4], sum_d[4];
   logic        [W-1:0]  mot_q[4], mot_d[4];
   logic                 sat_q, sat_d;

   logic signed [MW-1:0] t_x, y_x, p_x, r_x;

   // Difference is formed one bit wider so overflow can be detected and pinned.
   function automatic logic signed [W-1:0] sat_err(input logic signed [W-1:0] t,
                                                   input logic signed [W-1:0] a);
      logic signed [W:0] d;
      d = (W+1)'(t) - (W+1)'(a);
      if (d[W] != d[W-1]) return d[W] ? E_MIN : E_MAX;
      return d[W-1:0];
   endfunction

   function automatic logic signed [63:0] p_raw(input logic signed [W-1:0] e);
      return (64'(e) * 64'(RATE_KP)) >>> RATE_KP_SHIFT;
   endfunction

   function automatic logic signed [W-1:0] clamp_term(input logic signed [63:0] v);
      if (v > T_HI) return T_HI[W-1:0];
      if (v < T_LO) return T_LO[W-1:0];
      return v[W-1:0];
   endfunction

   function automatic logic [W-1:0] limit_val(input logic signed [MW-1:0] s);
      if (s[MW-1]) return '0;
      if (s > M_MAX) return M_MAX[W-1:0];
      return s[W-1:0];
   endfunction

   function automatic logic limit_clip(input logic signed [MW-1:0] s);
      return s[MW-1] || (s > M_MAX);
   endfunction

`ifdef RATE_INTEGRAL_EN
   localparam int ACC_W = 24;
   localparam logic signed [ACC_W:0] A_HI = (ACC_W+1)'(RATE_TERM_LIMIT << 4);
   localparam logic signed [ACC_W:0] A_LO = -A_HI;

   logic signed [ACC_W-1:0] acc_q[3], acc_d[3];

   function automatic logic signed [ACC_W-1:0] acc_step(input logic signed [ACC_W-1:0] acc,
                                                        input logic signed [W-1:0]     e);
      logic signed [ACC_W:0] s;
      s = (ACC_W+1)'(acc) + (ACC_W+1)'(e);
      if (s > A_HI) return A_HI[ACC_W-1:0];
      if (s < A_LO) return A_LO[ACC_W-1:0];
      return s[ACC_W-1:0];
   endfunction
`endif

   assign t_x = MW'(thr_q);
   assign y_x = MW'(term_q[AX_Y]);
   assign p_x = MW'(term_q[AX_P]);
   assign r_x = MW'(term_q[AX_R]);

   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) state_q <= ST_WAITING;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      active_signal   = 1'b0;
      complete_signal = 1'b0;
      unique case (state_q)
         ST_WAITING:  if (start_signal) state_d = ST_ERROR;
         ST_ERROR:    begin state_d = ST_SCALE;    active_signal = 1'b1; end
         ST_SCALE:    begin state_d = ST_MIX;      active_signal = 1'b1; end
         ST_MIX:      begin state_d = ST_LIMIT;    active_signal = 1'b1; end
         ST_LIMIT:    begin state_d = ST_COMPLETE; active_signal = 1'b1; end
         ST_COMPLETE: begin state_d = ST_WAITING;  complete_signal = 1'b1; end
         default:     state_d = ST_WAITING;
      endcase
   end

   always_comb begin
      thr_d = thr_q;
      sat_d = sat_q;
      for (int i = 0; i < 3; i++) begin
         tgt_d[i]  = tgt_q[i];
         act_d[i]  = act_q[i];
         err_d[i]  = err_q[i];
         term_d[i] = term_q[i];
`ifdef RATE_INTEGRAL_EN
         acc_d[i]  = acc_q[i];
`endif
      end
      for (int i = 0; i < 4; i++) begin
         sum_d[i] = sum_q[i];
         mot_d[i] = mot_q[i];
      end

      case (state_q)
         ST_WAITING: begin
            if (start_signal) begin
               thr_d       = throttle_rate_target;
               tgt_d[AX_Y] = yaw_rate_target;
               tgt_d[AX_P] = pitch_rate_target;
               tgt_d[AX_R] = roll_rate_target;
               act_d[AX_Y] = yaw_rate_actual;
               act_d[AX_P] = pitch_rate_actual;
               act_d[AX_R] = roll_rate_actual;
            end
         end
         ST_ERROR: begin
            for (int i = 0; i < 3; i++) err_d[i] = sat_err(tgt_q[i], act_q[i]);
         end
         ST_SCALE: begin
            for (int i = 0; i < 3; i++) begin
`ifdef RATE_INTEGRAL_EN
               // Ground anti-windup: integrators are held at zero while disarmed.
               acc_d[i]  = (thr_q == '0) ? '0 : acc_step(acc_q[i], err_q[i]);
               term_d[i] = clamp_term(p_raw(err_q[i]) + 64'(acc_d[i] >>> 4));
`else
               term_d[i] = clamp_term(p_raw(err_q[i]));
`endif
            end
         end
         ST_MIX: begin
            sum_d[M_FL] = t_x + p_x + r_x - y_x;
            sum_d[M_FR] = t_x + p_x - r_x + y_x;
            sum_d[M_RR] = t_x - p_x - r_x - y_x;
            sum_d[M_RL] = t_x - p_x + r_x + y_x;
         end
         ST_LIMIT: begin
            sat_d = 1'b0;
            for (int i = 0; i < 4; i++) begin
               mot_d[i] = limit_val(sum_q[i]);
               sat_d    = sat_d | limit_clip(sum_q[i]);
            end
            if (thr_q == '0) begin
               for (int i = 0; i < 4; i++) mot_d[i] = '0;
               sat_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         thr_q <= '0;
         sat_q <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            tgt_q[i]  <= '0;
            act_q[i]  <= '0;
            err_q[i]  <= '0;
            term_q[i] <= '0;
`ifdef RATE_INTEGRAL_EN
            acc_q[i]  <= '0;
`endif
         end
         for (int i = 0; i < 4; i++) begin
            sum_q[i] <= '0;
            mot_q[i] <= '0;
         end
      end else begin
         thr_q <= thr_d;
         sat_q <= sat_d;
         for (int i = 0; i < 3; i++) begin
            tgt_q[i]  <= tgt_d[i];
            act_q[i]  <= act_d[i];
            err_q[i]  <= err_d[i];
            term_q[i] <= term_d[i];
`ifdef RATE_INTEGRAL_EN
            acc_q[i]  <= acc_d[i];
`endif
         end
         for (int i = 0; i < 4; i++) begin
            sum_q[i] <= sum_d[i];
            mot_q[i] <= mot_d[i];
         end
      end
   end

   assign motor_fl        = mot_q[M_FL];
   assign motor_fr        = mot_q[M_FR];
   assign motor_rr        = mot_q[M_RR];
   assign motor_rl        = mot_q[M_RL];
   assign motor_saturated = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_body_rate_controller.sv
// ============================================================================
// Module   : tb_body_rate_controller
// Purpose  : Directed self-checking bench for body_rate_controller (default build)
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_body_rate_controller;

   logic        us_clk = 1'b0;
   logic        reset;
   logic        start_signal;
   logic [15:0] throttle_rate_target;
   logic [15:0] yaw_rate_target, pitch_rate_target, roll_rate_target;
   logic [15:0] yaw_rate_actual, pitch_rate_actual, roll_rate_actual;
   logic [15:0] motor_fl, motor_fr, motor_rr, motor_rl;
   logic        motor_saturated, active_signal, complete_signal;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_done;
   int act_cnt;

   body_rate_controller dut (
      .us_clk               (us_clk),
      .reset                (reset),
      .start_signal         (start_signal),
      .throttle_rate_target (throttle_rate_target),
      .yaw_rate_target      (yaw_rate_target),
      .pitch_rate_target    (pitch_rate_target),
      .roll_rate_target     (roll_rate_target),
      .yaw_rate_actual      (yaw_rate_actual),
      .pitch_rate_actual    (pitch_rate_actual),
      .roll_rate_actual     (roll_rate_actual),
      .motor_fl             (motor_fl),
      .motor_fr             (motor_fr),
      .motor_rr             (motor_rr),
      .motor_rl             (motor_rl),
      .motor_saturated      (motor_saturated),
      .active_signal        (active_signal),
      .complete_signal      (complete_signal)
   );

   always #5 us_clk = ~us_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic apply(input logic [15:0] thr, yt, pt, rt, ya, pa, ra);
      throttle_rate_target = thr;
      yaw_rate_target      = yt;
      pitch_rate_target    = pt;
      roll_rate_target     = rt;
      yaw_rate_actual      = ya;
      pitch_rate_actual    = pa;
      roll_rate_actual     = ra;
   endtask

   // Cycle 1 is the cycle right after the capture edge; cyc_done stays 0 on timeout.
   task automatic run_once(input logic [15:0] thr, yt, pt, rt, ya, pa, ra);
      @(posedge us_clk);
      @(negedge us_clk);
      apply(thr, yt, pt, rt, ya, pa, ra);
      start_signal = 1'b1;
      @(posedge us_clk);
      #1 start_signal = 1'b0;
      cyc_done = 0;
      act_cnt  = 0;
      for (int c = 1; c <= 20; c++) begin
         if (active_signal) act_cnt++;
         if (complete_signal) begin
            cyc_done = c;
            break;
         end
         @(posedge us_clk);
         #1;
      end
   endtask

   task automatic test_reset;
      logic [66:0] got;
      reset        = 1'b1;
      start_signal = 1'b0;
      apply(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      repeat (2) @(posedge us_clk);
      #1;
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated, active_signal, complete_signal};
      n_tests++;
      if (got !== 67'h0) begin
         n_fail++;
         $display("FAIL reset_values: got %h, expected %h", got, 67'h0);
      end
      @(negedge us_clk);
      reset = 1'b0;
   endtask

   task automatic test_hover;
      logic [64:0] got, exp;
      run_once(16'h0400, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      n_tests++;
      if (cyc_done !== 5) begin
         n_fail++;
         $display("FAIL hover_latency: got %0d, expected %0d", cyc_done, 5);
      end
      n_tests++;
      if (act_cnt !== 4) begin
         n_fail++;
         $display("FAIL hover_active_cycles: got %0d, expected %0d", act_cnt, 4);
      end
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0400, 16'h0400, 16'h0400, 16'h0400, 1'b0};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL hover_motors: got %h, expected %h", got, exp);
      end
   endtask

   task automatic test_pitch_step;
      logic [64:0] got, exp;
      run_once(16'h0400, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0);
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0500, 16'h0500, 16'h0300, 16'h0300, 1'b0};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL pitch_step_motors: got %h, expected %h", got, exp);
      end
   endtask

   task automatic test_mixed_axes;
      logic [64:0] got, exp;
      // Y err +16, P err -48, R err +64, gain 1.0
      run_once(16'h0800, 16'h0020, 16'h0000, 16'h0040, 16'h0010, 16'h0030, 16'h0000);
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0800, 16'h07A0, 16'h07E0, 16'h0880, 1'b0};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL mixed_axes_motors: got %h, expected %h", got, exp);
      end
   endtask

   task automatic test_saturation;
      logic [64:0] got, exp;
      run_once(16'h0F00, 16'h0, 16'h0190, 16'h0, 16'h0, 16'h0, 16'h0);
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0FA0, 16'h0FA0, 16'h0D70, 16'h0D70, 1'b1};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL sat_high_motors: got %h, expected %h", got, exp);
      end
      run_once(16'h0040, 16'h0, 16'h0, 16'hFF00, 16'h0, 16'h0, 16'h0);
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0000, 16'h0140, 16'h0140, 16'h0000, 1'b1};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL sat_low_motors: got %h, expected %h", got, exp);
      end
   endtask

   task automatic test_disarm;
      logic [64:0] got, exp;
      run_once(16'h0000, 16'h0200, 16'h0100, 16'hFF00, 16'h0, 16'h0, 16'h0);
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = 65'h0;
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL disarm_motors: got %h, expected %h", got, exp);
      end
   endtask

   task automatic test_term_clamp;
      logic [64:0] got, exp;
      // +full-scale error: 0x7FFF after saturation, term clamped to +0x0400
      run_once(16'h0800, 16'h7FF0, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h0);
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0400, 16'h0C00, 16'h0400, 16'h0C00, 1'b0};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL term_clamp_pos_motors: got %h, expected %h", got, exp);
      end
      run_once(16'h0800, 16'h8000, 16'h0, 16'h0, 16'h7FF0, 16'h0, 16'h0);
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0C00, 16'h0400, 16'h0C00, 16'h0400, 1'b0};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL term_clamp_neg_motors: got %h, expected %h", got, exp);
      end
   endtask

   task automatic test_reset_mid_run;
      logic [66:0] got;
      logic [64:0] mot, exp;
      @(posedge us_clk);
      @(negedge us_clk);
      apply(16'h0400, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0);
      start_signal = 1'b1;
      @(posedge us_clk);
      #1 start_signal = 1'b0;
      repeat (2) @(posedge us_clk);
      #1;
      n_tests++;
      if (active_signal !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_run_active_before_reset: got %b, expected %b", active_signal, 1'b1);
      end
      reset = 1'b1;
      #1;
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated, active_signal, complete_signal};
      n_tests++;
      if (got !== 67'h0) begin
         n_fail++;
         $display("FAIL mid_run_reset_outputs: got %h, expected %h", got, 67'h0);
      end
      @(negedge us_clk);
      reset = 1'b0;
      run_once(16'h0400, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
      n_tests++;
      if (cyc_done !== 5) begin
         n_fail++;
         $display("FAIL post_reset_latency: got %0d, expected %0d", cyc_done, 5);
      end
      mot = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0400, 16'h0400, 16'h0400, 16'h0400, 1'b0};
      n_tests++;
      if (mot !== exp) begin
         n_fail++;
         $display("FAIL post_reset_motors: got %h, expected %h", mot, exp);
      end
   endtask

   task automatic test_start_busy;
      int          pulses;
      logic [64:0] got, exp;
      @(posedge us_clk);
      @(negedge us_clk);
      apply(16'h0400, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0);
      start_signal = 1'b1;
      @(posedge us_clk);
      #1 start_signal = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 14; c++) begin
         if (complete_signal) pulses++;
         if (c == 2) begin
            // Second request lands while the run is in SCALE
            @(negedge us_clk);
            apply(16'h0800, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
            start_signal = 1'b1;
            @(posedge us_clk);
            #1 start_signal = 1'b0;
         end else begin
            @(posedge us_clk);
            #1;
         end
      end
      n_tests++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL busy_complete_pulses: got %0d, expected %0d", pulses, 1);
      end
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0500, 16'h0500, 16'h0300, 16'h0300, 1'b0};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL busy_motors: got %h, expected %h", got, exp);
      end
   endtask

   task automatic test_back_to_back;
      int          pulses, first_c, second_c;
      logic [64:0] got, exp;
      @(posedge us_clk);
      @(negedge us_clk);
      apply(16'h0800, 16'h0020, 16'h0000, 16'h0040, 16'h0010, 16'h0030, 16'h0000);
      start_signal = 1'b1;
      @(posedge us_clk);
      #1;
      pulses   = 0;
      first_c  = 0;
      second_c = 0;
      for (int c = 1; c <= 13; c++) begin
         if (complete_signal) begin
            pulses++;
            if (first_c == 0) first_c = c;
            else              second_c = c;
         end
         if (c == 11) start_signal = 1'b0;
         @(posedge us_clk);
         #1;
      end
      n_tests++;
      if (pulses !== 2) begin
         n_fail++;
         $display("FAIL b2b_pulse_count: got %0d, expected %0d", pulses, 2);
      end
      n_tests++;
      if (first_c !== 5 || second_c !== 11) begin
         n_fail++;
         $display("FAIL b2b_pulse_cycles: got %0d/%0d, expected %0d/%0d", first_c, second_c, 5, 11);
      end
      got = {motor_fl, motor_fr, motor_rr, motor_rl, motor_saturated};
      exp = {16'h0800, 16'h07A0, 16'h07E0, 16'h0880, 1'b0};
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL b2b_motors: got %h, expected %h", got, exp);
      end
   endtask

   initial begin
      test_reset();
      test_hover();
      test_pitch_step();
      test_mixed_axes();
      test_saturation();
      test_disarm();
      test_term_clamp();
      test_reset_mid_run();
      test_start_busy();
      test_back_to_back();
      repeat (2) @(posedge us_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/body_rate_controller.md
Name: body_rate_controller

Overview:
- Downstream consumer of the angle controller's outputs; converts limited throttle/yaw/pitch/roll rate targets plus IMU body rates into four motor commands.
- Started by the angle controller's complete pulse; returns its own start/active/complete handshake to the motor PWM stage.
- Per axis: proportional rate loop, quad-X mixing, output saturation.

Parameters:
- RATE_BIT_WIDTH, 16, width of all rate/motor values (signed Q12.4 for rates)
- RATE_KP, 4, unsigned integer proportional gain, all axes
- RATE_KP_SHIFT, 2, arithmetic right shift after gain multiply (default gain 1.0)
- RATE_TERM_LIMIT, 16'h0400, symmetric clamp on each axis correction (+/-64.0)
- MOTOR_MAX, 16'h0FA0, maximum motor command (250.0)

Ports:
- us_clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start_signal  in  1  run request; driven by angle controller complete_signal
- throttle_rate_target  in  16  throttle, unsigned Q12.4
- yaw_rate_target, pitch_rate_target, roll_rate_target  in  16 each  signed Q12.4 deg/s
- yaw_rate_actual, pitch_rate_actual, roll_rate_actual  in  16 each  signed Q12.4 deg/s from IMU
- motor_fl, motor_fr, motor_rr, motor_rl  out  16 each  unsigned Q12.4 motor commands
- motor_saturated  out  1  a motor clipped on the last run
- active_signal  out  1  computation in progress
- complete_signal  out  1  one-cycle done pulse

Behaviour:
- One clock (us_clk). Reset is asynchronous and active-high (reset).
- Reset values: all motor outputs 0, motor_saturated 0, active_signal 0, complete_signal 0, state WAITING, internal registers 0. Reset asserted mid-run aborts immediately and returns to these values.
- State machine: WAITING -> ERROR -> SCALE -> MIX -> LIMIT -> COMPLETE -> WAITING. Every state except WAITING lasts exactly one cycle.
- WAITING: on the us_clk edge where start_signal=1, all seven inputs are latched and the state moves to ERROR. start_signal is ignored in every other state; no queueing.
- ERROR: err_axis = target - actual, computed at 17 bits, then saturated to 16-bit signed (0x7FFF / 0x8000).
- SCALE: term = (err * RATE_KP) >>> RATE_KP_SHIFT (arithmetic shift), then clamped to +/-RATE_TERM_LIMIT.
- MIX: 19-bit signed sums, with T = zero-extended throttle:
  - fl = T + P + R - Y
  - fr = T + P - R + Y
  - rr = T - P - R - Y
  - rl = T - P + R + Y
- LIMIT: each sum is clamped to [0, MOTOR_MAX]. motor_saturated=1 if any sum clipped.
- Disarm: if latched throttle == 0, all motors are 0 and motor_saturated is 0, regardless of other inputs.
- Motor outputs and motor_saturated register on the edge entering COMPLETE and hold until the next run or reset.
- active_signal: 1 in ERROR, SCALE, MIX and LIMIT; 0 otherwise.
- complete_signal: 1 only in COMPLETE, asserted 5 cycles after the start-capture edge.
- Back-to-back: start_signal held high re-captures on the first WAITING cycle, giving a 6-cycle period.

Optional Feature:
- Macro: RATE_INTEGRAL_EN.
- When defined:
  - Each axis has a 24-bit signed accumulator. In SCALE it adds err and clamps to +/-(RATE_TERM_LIMIT<<4).
  - term = clamp(P + (acc >>> 4), +/-RATE_TERM_LIMIT).
  - Accumulators clear on reset and whenever the latched throttle == 0 (ground anti-windup).
- When undefined: no accumulators exist; pure P behaviour as above.

Test Plan:
- Reset mid-run: assert reset while in MIX -> all outputs 0 immediately; next start produces complete 5 cycles after capture.
- Hover: throttle 0x0400, all targets and actuals 0, start pulse -> complete 5 cycles after capture; all motors 0x0400; active high 4 cycles; saturated 0.
- Pitch step: throttle 0x0400, pitch target 0x0100, actual 0 -> fl=fr=0x0500, rr=rl=0x0300.
- Saturation:
  - throttle 0x0F00, pitch target 0x0190 -> fl=fr=0x0FA0, saturated=1.
  - throttle 0x0040, roll target 0xFF00 -> fl=rl=0x0000, fr=rr=0x0140.
- Term clamp and disarm:
  - yaw target 0x7FF0, actual 0x8000 -> err saturates to 0x7FFF, term 0x0400.
  - throttle 0 with any targets -> all motors 0.
- Start during busy: second start pulse in SCALE is ignored -> exactly one complete pulse.
- With RATE_INTEGRAL_EN: constant pitch err 0x0010 over 3 runs -> term grows by 1 each run; throttle 0 run clears the accumulator.
